// File: rtl/prim_reg_fe_pkg.sv
// Shared types and constants for the register bus front end.
package prim_reg_fe_pkg;

    localparam int unsigned REG_STRIDE = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_RANGE    = 2'd2,
        ERR_PARTIAL  = 2'd3
    } err_e;

endpackage

// File: rtl/prim_reg_fe_decode.sv
// Word-address decode: one-hot register select plus the reason a request is rejected.
module prim_reg_fe_decode
    import prim_reg_fe_pkg::*;
#(
    parameter int unsigned AW   = 8,
    parameter int unsigned DW   = 32,
    parameter int unsigned NREG = 8
) (
    input  logic [AW-1:0]   addr_i,
    input  logic            write_i,
    input  logic [DW/8-1:0] be_i,
    output logic [NREG-1:0] sel_o,
    output err_e            err_o
);

    localparam int unsigned OFFW = $clog2(REG_STRIDE);
    localparam int unsigned IXW  = AW - OFFW + 1;

    // One spare bit so NREG == 2^(AW-2) still compares correctly
    logic [IXW-1:0] idx_ext;
    assign idx_ext = {1'b0, addr_i[AW-1:OFFW]};

    always_comb begin
        err_o = ERR_NONE;
        if (addr_i[OFFW-1:0] != '0) begin
            err_o = ERR_MISALIGN;
        end else if (idx_ext >= IXW'(NREG)) begin
            err_o = ERR_RANGE;
        end else if (write_i && (be_i != '1)) begin
            err_o = ERR_PARTIAL;
        end
    end

    always_comb begin
        sel_o = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            sel_o[i] = (err_o == ERR_NONE) && (idx_ext == IXW'(i));
        end
    end

endmodule

// File: rtl/prim_reg_frontend.sv
// Valid/ready register front end: one request at a time, single-cycle register pulse, held response.
// Define PRIM_REG_FE_ERR_EN to report decode errors on rsp_error_o (otherwise tied low).
module prim_reg_frontend
    import prim_reg_fe_pkg::*;
#(
    parameter int unsigned AW   = 8,
    parameter int unsigned DW   = 32,
    parameter int unsigned NREG = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_write_i,
    input  logic [AW-1:0]      req_addr_i,
    input  logic [DW-1:0]      req_wdata_i,
    input  logic [DW/8-1:0]    req_be_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [DW-1:0]      rsp_rdata_o,
    output logic               rsp_error_o,
    output logic [NREG-1:0]    reg_we_o,
    output logic [NREG-1:0]    reg_re_o,
    output logic [DW-1:0]      reg_wd_o,
    input  logic [NREG*DW-1:0] reg_qs_i
);

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic              rsp_error_q, rsp_error_d;
    logic [NREG-1:0]   reg_we_q, reg_we_d;
    logic [NREG-1:0]   reg_re_q, reg_re_d;
    logic [DW-1:0]     reg_wd_q, reg_wd_d;
`ifdef PRIM_REG_FE_ERR_EN
    err_e              err_q, err_d;
`endif

    logic [NREG-1:0]   dec_sel;
    err_e              dec_err;
    logic              req_hs;
    logic              rsp_hs;
    logic [DW-1:0]     rd_mux;

    // Decoded at acceptance so the select and cause are latched with the request
    prim_reg_fe_decode #(
        .AW   (AW),
        .DW   (DW),
        .NREG (NREG)
    ) u_decode (
        .addr_i  (req_addr_i),
        .write_i (req_write_i),
        .be_i    (req_be_i),
        .sel_o   (dec_sel),
        .err_o   (dec_err)
    );

    assign req_hs = req_valid_i & req_ready_q & (state_q == ST_IDLE);
    assign rsp_hs = rsp_valid_q & rsp_ready_i;

    // Read pulse doubles as the mux select; zero for writes and errors
    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (reg_re_q[i]) begin
                rd_mux = rd_mux | reg_qs_i[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_d = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        reg_we_d    = '0;
        reg_re_d    = '0;
        reg_wd_d    = reg_wd_q;
`ifdef PRIM_REG_FE_ERR_EN
        err_d       = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (req_hs) begin
                    state_d     = ST_ACCESS;
                    req_ready_d = 1'b0;
`ifdef PRIM_REG_FE_ERR_EN
                    err_d       = dec_err;
`endif
                    if (req_write_i) begin
                        reg_we_d = dec_sel;
                        if (dec_err == ERR_NONE) begin
                            reg_wd_d = req_wdata_i;
                        end
                    end else begin
                        reg_re_d = dec_sel;
                    end
                end
            end
            ST_ACCESS: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = rd_mux;
`ifdef PRIM_REG_FE_ERR_EN
                rsp_error_d = (err_q != ERR_NONE);
`else
                rsp_error_d = 1'b0;
`endif
            end
            ST_RESP: begin
                if (rsp_hs) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            reg_we_q    <= '0;
            reg_re_q    <= '0;
            reg_wd_q    <= '0;
`ifdef PRIM_REG_FE_ERR_EN
            err_q       <= ERR_NONE;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            reg_wd_q    <= reg_wd_d;
`ifdef PRIM_REG_FE_ERR_EN
            err_q       <= err_d;
`endif
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_error_o = rsp_error_q;
    assign reg_we_o    = reg_we_q;
    assign reg_re_o    = reg_re_q;
    assign reg_wd_o    = reg_wd_q;

endmodule

// File: tb/tb_prim_reg_frontend.sv
// Directed bench for prim_reg_frontend: vector table plus hand sequences for multi-cycle cases.
module tb_prim_reg_frontend;

    localparam int unsigned AW   = 8;
    localparam int unsigned DW   = 32;
    localparam int unsigned NREG = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                req_valid, req_ready, req_write;
    logic [AW-1:0]       req_addr;
    logic [DW-1:0]       req_wdata;
    logic [DW/8-1:0]     req_be;
    logic                rsp_valid, rsp_ready, rsp_error;
    logic [DW-1:0]       rsp_rdata;
    logic [NREG-1:0]     reg_we, reg_re;
    logic [DW-1:0]       reg_wd;
    logic [NREG*DW-1:0]  reg_qs;

    logic                rtc_en = 1'b0;
    logic                rtc_cleared = 1'b0;

    int unsigned         n_chk = 0;
    int unsigned         n_fail = 0;
    logic [DW-1:0]       exp_wd = '0;

    always #5 clk = ~clk;

    prim_reg_frontend #(.AW(AW), .DW(DW), .NREG(NREG)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_be_i    (req_be),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_error_o (rsp_error),
        .reg_we_o    (reg_we),
        .reg_re_o    (reg_re),
        .reg_wd_o    (reg_wd),
        .reg_qs_i    (reg_qs)
    );

    // Register file model: reg i reads 0x5A00_000i, reg 7 is read-to-clear 0xA5
    always_comb begin
        for (int i = 0; i < NREG; i++) reg_qs[i*DW +: DW] = 32'h5A00_0000 + 32'(i);
        reg_qs[7*DW +: DW] = rtc_cleared ? 32'h0 : 32'h0000_00A5;
    end

    always @(posedge clk) if (rtc_en && reg_re[7]) rtc_cleared <= 1'b1;

    typedef struct packed {
        logic        write;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [7:0]  exp_we;
        logic [7:0]  exp_re;
        logic [31:0] exp_rdata;
        logic        err;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic err_exp(input logic e);
`ifdef PRIM_REG_FE_ERR_EN
        return e;
`else
        return 1'b0 & e;
`endif
    endfunction

    task automatic wait_ready(input string tag);
        int cyc = 0;
        while (req_ready !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (req_ready !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: req_ready_o never rose (got %b, expected 1)", tag, req_ready);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        wait_ready(tag);
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_be    = v.be;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (v.exp_we != '0) exp_wd = v.wdata;
        chk({tag, " we"},        64'(reg_we),    64'(v.exp_we));
        chk({tag, " re"},        64'(reg_re),    64'(v.exp_re));
        chk({tag, " wd"},        64'(reg_wd),    64'(exp_wd));
        chk({tag, " ready acc"}, 64'(req_ready), 64'(0));
        chk({tag, " valid acc"}, 64'(rsp_valid), 64'(0));
        @(posedge clk); #1;
        chk({tag, " pulses off"}, 64'({reg_we, reg_re}), 64'(0));
        chk({tag, " valid"},      64'(rsp_valid), 64'(1));
        chk({tag, " rdata"},      64'(rsp_rdata), 64'(v.exp_rdata));
        chk({tag, " error"},      64'(rsp_error), 64'(err_exp(v.err)));
        @(posedge clk); #1;
        chk({tag, " valid drop"}, 64'(rsp_valid), 64'(0));
    endtask

    vec_t vecs[10];
    vec_t v;
    logic [31:0] held;
    logic        seen;
    int          k, npulse, nrsp, cyc, last;
    logic        acc;

    initial begin
        vecs[0] = '{1'b1, 8'h08, 32'hDEADBEEF, 4'hF, 8'h04, 8'h00, 32'h0,         1'b0};
        vecs[1] = '{1'b0, 8'h1C, 32'h11111111, 4'hF, 8'h00, 8'h80, 32'h0000_00A5, 1'b0};
        vecs[2] = '{1'b0, 8'h20, 32'h0,        4'hF, 8'h00, 8'h00, 32'h0,         1'b1};
        vecs[3] = '{1'b0, 8'h06, 32'h0,        4'hF, 8'h00, 8'h00, 32'h0,         1'b1};
        vecs[4] = '{1'b1, 8'h04, 32'h11112222, 4'h3, 8'h00, 8'h00, 32'h0,         1'b1};
        vecs[5] = '{1'b0, 8'h00, 32'h0,        4'h0, 8'h00, 8'h01, 32'h5A00_0000, 1'b0};
        vecs[6] = '{1'b1, 8'h1C, 32'h12345678, 4'hF, 8'h80, 8'h00, 32'h0,         1'b0};
        vecs[7] = '{1'b0, 8'h10, 32'h0,        4'hF, 8'h00, 8'h10, 32'h5A00_0004, 1'b0};
        vecs[8] = '{1'b1, 8'hFF, 32'hBAD0BAD0, 4'hF, 8'h00, 8'h00, 32'h0,         1'b1};
        vecs[9] = '{1'b1, 8'h0C, 32'h0F0F0F0F, 4'hF, 8'h08, 8'h00, 32'h0,         1'b0};

        req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0;   req_be = '0;      rsp_ready = 1'b1;

        #1;
        chk("reset ready", 64'(req_ready), 64'(0));
        chk("reset valid", 64'(rsp_valid), 64'(0));
        chk("reset outs",  64'({reg_we, reg_re, rsp_error}), 64'(0));
        chk("reset rdata", 64'(rsp_rdata), 64'(0));
        chk("reset wd",    64'(reg_wd),    64'(0));
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready after reset", 64'(req_ready), 64'(1));

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Read-to-clear: pulse edge clears the model, response must carry the old value
        rtc_en = 1'b1;
        v = '{1'b0, 8'h1C, 32'h0, 4'hF, 8'h00, 8'h80, 32'h0000_00A5, 1'b0};
        run_vec(v, "rtc first");
        v.exp_rdata = 32'h0;
        run_vec(v, "rtc second");
        rtc_en = 1'b0;

        // Backpressure with a second request waiting
        wait_ready("bp");
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h04; req_be = 4'hF;
        @(posedge clk); #1;
        req_addr = 8'h08;
        chk("bp re first", 64'(reg_re), 64'(8'h02));
        @(posedge clk); #1;
        chk("bp valid", 64'(rsp_valid), 64'(1));
        chk("bp rdata", 64'(rsp_rdata), 64'(32'h5A00_0001));
        held = rsp_rdata;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp hold valid c%0d", c), 64'(rsp_valid), 64'(1));
            chk($sformatf("bp hold rdata c%0d", c), 64'(rsp_rdata), 64'(32'h5A00_0001));
            chk($sformatf("bp hold ready c%0d", c), 64'(req_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp valid drop", 64'(rsp_valid), 64'(0));
        chk("bp ready back", 64'(req_ready), 64'(1));
        chk("bp no early re", 64'(reg_re), 64'(0));
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp re second", 64'(reg_re), 64'(8'h04));
        @(posedge clk); #1;
        chk("bp rdata second", 64'(rsp_rdata), 64'(32'h5A00_0002));
        @(posedge clk); #1;

        // Reset during the ACCESS cycle of a write
        wait_ready("rst");
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h00;
        req_wdata = 32'hCAFEF00D; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst we before", 64'(reg_we), 64'(8'h01));
        #2 rst_n = 1'b0;
        #1;
        chk("rst we cleared", 64'(reg_we), 64'(0));
        chk("rst wd cleared", 64'(reg_wd), 64'(0));
        chk("rst ready low",  64'(req_ready), 64'(0));
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b1;
        exp_wd = '0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (rsp_valid || reg_we != '0) seen = 1'b1;
        end
        chk("rst no response", 64'(seen), 64'(0));
        chk("rst ready after", 64'(req_ready), 64'(1));

        // Back-to-back writes with valid held high
        k = 0; npulse = 0; nrsp = 0; cyc = 0; last = 0;
        req_valid = 1'b1; req_write = 1'b1; req_be = 4'hF;
        req_addr = 8'h00; req_wdata = 32'h100;
        while ((npulse < 4 || nrsp < 4) && cyc < 60) begin
            acc = req_ready && req_valid;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                k++;
                if (k < 4) begin
                    req_addr  = 8'(4 * k);
                    req_wdata = 32'h100 + 32'(k);
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (reg_we != '0) begin
                chk($sformatf("b2b pulse %0d", npulse), 64'(reg_we), 64'(8'h01 << npulse));
                chk($sformatf("b2b wd %0d", npulse), 64'(reg_wd), 64'(32'h100 + 32'(npulse)));
                if (npulse > 0) chk($sformatf("b2b spacing %0d", npulse), 64'(cyc - last), 64'(3));
                last = cyc;
                npulse++;
            end
            if (rsp_valid) nrsp++;
        end
        chk("b2b pulses", 64'(npulse), 64'(4));
        chk("b2b responses", 64'(nrsp), 64'(4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/prim_reg_frontend.md
Name: prim_reg_frontend

Overview:
- Bus-side register front end that drives the software ports of a bank of register slices.
- Each slice takes a software write pulse and write data, and returns its current read value.
- Accepts one valid/ready request at a time and decodes its word address.
- Issues a single-cycle write or read pulse to the selected register, captures read data, and returns a response over a valid/ready channel.
- Sits between the platform interconnect adapter and the per-block register file (e.g. interrupt controller registers).

Parameters:
- AW, 8, request address width in bits (byte address).
- DW, 32, data width; must be a multiple of 8.
- NREG, 8, number of registers; register i sits at byte offset 4*i; requires NREG <= 2^(AW-2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_write_i  in  1  1 = write, 0 = read
- req_addr_i  in  AW  byte address
- req_wdata_i  in  DW  write data
- req_be_i  in  DW/8  byte enables
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_rdata_o  out  DW  read data; 0 for writes and errors
- rsp_error_o  out  1  decode error
- reg_we_o  out  NREG  one-hot write pulse per register
- reg_re_o  out  NREG  one-hot read pulse per register (drives the write-enable of read-to-clear registers)
- reg_wd_o  out  DW  write data to all registers
- reg_qs_i  in  NREG*DW  register read values; register i occupies bits [i*DW +: DW]

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- While reset is asserted: state IDLE; req_ready_o = 0; rsp_valid_o = 0; rsp_rdata_o = 0; rsp_error_o = 0; reg_we_o = 0; reg_re_o = 0; reg_wd_o = 0.
- IDLE:
  - req_ready_o = 1.
  - A request is accepted when req_valid_i & req_ready_o at a rising edge (edge N).
  - On acceptance, latch write, address, wdata and be, then go to ACCESS.
- ACCESS (exactly one cycle, N to N+1):
  - A request is an error if any of these hold: addr[1:0] != 0; addr[AW-1:2] >= NREG; write with be != all-ones.
  - Hit write: reg_we_o[idx] = 1 and reg_wd_o = latched wdata, for this cycle only.
  - Hit read: reg_re_o[idx] = 1 for this cycle only.
  - Read data is captured into rsp_rdata_o from reg_qs_i[idx] at edge N+1. This is the pre-update value, so read-to-clear registers return the value before the clear.
  - Error: no pulse on reg_we_o or reg_re_o; rdata = 0.
  - Go to RESP.
- RESP:
  - rsp_valid_o = 1 from cycle N+1.
  - rsp_rdata_o and rsp_error_o are held stable until rsp_valid_o & rsp_ready_i.
  - On that handshake go to IDLE; rsp_valid_o drops the next cycle.
  - req_ready_o = 0 in ACCESS and RESP; at most one request is outstanding.
- Latency and throughput:
  - Accept at edge N, register pulse during cycle N to N+1, response valid from N+1.
  - Minimum three cycles per transaction.
- Outputs are registered:
  - reg_we_o and reg_re_o are never asserted outside ACCESS.
  - reg_wd_o holds its last value between writes.
- Reset asserted mid-transaction (any state): all outputs clear immediately. No pulse is emitted and no response is delivered. The request is lost.
- rsp_ready_i high while not in RESP is ignored.

Optional Feature:
- Macro: PRIM_REG_FE_ERR_EN.
- Defined: decode errors are reported with rsp_error_o = 1.
- Undefined:
  - rsp_error_o is tied to 0.
  - Erroneous requests still produce no register pulse and return rdata 0, and still complete with a normal response handshake.

Decomposition:
- Package prim_reg_fe_pkg holds:
  - state enum (IDLE, ACCESS, RESP), 2 bits;
  - error cause enum (NONE, MISALIGN, RANGE, PARTIAL);
  - the constant REG_STRIDE = 4.
- One combinational sub-module, prim_reg_fe_decode, maps the latched addr, write and be to a one-hot select of width NREG plus an error cause.

Test Plan:
- Write: addr 0x08, wdata 0xDEADBEEF, be 0xF → reg_we_o = 0x04 for exactly one cycle after acceptance; reg_wd_o = 0xDEADBEEF; response next cycle with error 0 and rdata 0.
- Read: reg_qs_i[7] = 0x000000A5, read addr 0x1C → reg_re_o = 0x80 for one cycle; rsp_rdata_o = 0x000000A5, error 0. A qs change to 0 at the pulse edge must still return 0xA5.
- Range and misalign:
  - read 0x20 → error 1 (when PRIM_REG_FE_ERR_EN is defined), rdata 0, no pulses;
  - read 0x06 → same result;
  - write 0x04 with be 0x3 → error 1 and reg_we_o stays 0.
- Backpressure: rsp_ready_i held low 5 cycles, with a second request pending → rsp_valid_o high, rdata stable, req_ready_o 0 throughout. The second request is accepted in the cycle after the response handshake.
- Reset in ACCESS: deassert rst_ni during a write's ACCESS cycle → reg_we_o drops immediately, no response is ever seen, and req_ready_o = 1 after reset release.
- Back-to-back: 4 writes to addresses 0x00 through 0x0C, valid held high → one-hot pulses 0x01, 0x02, 0x04, 0x08 spaced 3 cycles apart, 4 responses delivered.
